ac97_frame_sched: RTL

Frame scheduler for the AC97 link: on a play request it runs the codec init sequence (reset, master volume, PCM volume) through command slots 1/2, then streams one PCM sample per frame from the song ROM into slots 3/4. During playback it also inserts extra codec register writes from a command port. It drives the 256-bit frame word consumed by the AC97 link block, and advances only on that block's frame strobe.

---
 rtl/ac97_pkg.sv | 57 +++++
 rtl/ac97_frame_pack.sv | 22 ++
 rtl/ac97_frame_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ac97_pkg.sv
// Shared types and constants for the AC97 frame scheduler: FSM states,
// codec init register writes and the slot layout of the 256-bit frame.
package ac97_pkg;

  localparam int FRAME_W   = 256;
  localparam int SLOT_W    = 20;
  localparam int SLOT1_OFS = 16;
  localparam int SLOT2_OFS = 36;
  localparam int SLOT3_OFS = 56;
  localparam int SLOT4_OFS = 76;

  localparam logic [6:0]  REG_RESET       = 7'h00;
  localparam logic [6:0]  REG_MASTER_VOL  = 7'h02;
  localparam logic [6:0]  REG_PCM_VOL     = 7'h18;
  localparam logic [15:0] INIT_RESET      = 16'h0000;
  localparam logic [15:0] INIT_MASTER_VOL = 16'h0000;
  localparam logic [15:0] INIT_PCM_VOL    = 16'h0808;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_MVOL,
    ST_PVOL,
    ST_PLAY
  } state_e;

  // Bit 0 is the first bit on the wire, so the frame is ascending-indexed.
  typedef logic [0:FRAME_W-1] frame_t;

  // valid[0] is slot 1 ... valid[3] is slot 4.
  typedef struct packed {
    logic        tag;
    logic [3:0]  valid;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [15:0] pcm;
  } frame_fields_t;

  function automatic logic [6:0] init_cmd_addr(input state_e s);
    case (s)
      ST_RST:  init_cmd_addr = REG_RESET;
      ST_MVOL: init_cmd_addr = REG_MASTER_VOL;
      ST_PVOL: init_cmd_addr = REG_PCM_VOL;
      default: init_cmd_addr = 7'h00;
    endcase
  endfunction

  function automatic logic [15:0] init_cmd_data(input state_e s);
    case (s)
      ST_RST:  init_cmd_data = INIT_RESET;
      ST_MVOL: init_cmd_data = INIT_MASTER_VOL;
      ST_PVOL: init_cmd_data = INIT_PCM_VOL;
      default: init_cmd_data = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/ac97_frame_pack.sv
// Combinational packer: turns tag/valid flags, command and PCM fields into
// the 256-bit AC97 output frame. Slots not flagged valid stay all-zero.
module ac97_frame_pack
  import ac97_pkg::*;
(
  input  frame_fields_t fields_i,
  output frame_t        frame_o
);

  always_comb begin
    frame_o    = '0;
    frame_o[0] = fields_i.tag;
    for (int i = 0; i < 4; i++) begin
      frame_o[1+i] = fields_i.valid[i];
    end
    if (fields_i.valid[0]) frame_o[SLOT1_OFS +: SLOT_W] = {1'b0, fields_i.cmd_addr, 12'h000};
    if (fields_i.valid[1]) frame_o[SLOT2_OFS +: SLOT_W] = {fields_i.cmd_data, 4'h0};
    if (fields_i.valid[2]) frame_o[SLOT3_OFS +: SLOT_W] = {fields_i.pcm, 4'h0};
    if (fields_i.valid[3]) frame_o[SLOT4_OFS +: SLOT_W] = {fields_i.pcm, 4'h0};
  end

endmodule

// File: rtl/ac97_frame_sched.sv
// AC97 frame scheduler: codec init sequence, then one PCM sample per frame
// from the song ROM, with optional codec register writes riding along.
module ac97_frame_sched
  import ac97_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int INIT_FRAMES = 2
) (
  input  logic              ac97_bitclk,
  input  logic              rst,
  input  logic              ac97_strobe,
  input  logic              play,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] smp_addr,
  input  logic [15:0]       smp_data,
  input  logic              cmd_valid,
  input  logic [6:0]        cmd_addr,
  input  logic [15:0]       cmd_data,
  output logic              cmd_ready,
  output logic [0:255]      frame,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(INIT_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_FRAMES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              done_q, done_d;
  frame_t            frame_q, frame_d, frame_packed;
  frame_fields_t     fields;
  logic              frame_load;
  logic              at_end;

  assign at_end = (smp_addr_q == len_q);

  ac97_frame_pack u_pack (
    .fields_i (fields),
    .frame_o  (frame_packed)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    smp_addr_d = smp_addr_q;
    len_d      = len_q;
    done_d     = 1'b0;
    frame_load = 1'b0;
    fields     = '0;
    fields.tag = 1'b1;

    case (state_q)
      ST_IDLE: begin
        frame_load = ac97_strobe;
        if (play) begin
          state_d    = ST_RST;
          len_d      = song_len;
          smp_addr_d = '0;
          init_cnt_d = '0;
        end
      end

      ST_RST, ST_MVOL, ST_PVOL: begin
        if (ac97_strobe) begin
          frame_load      = 1'b1;
          fields.valid    = 4'b0011;
          fields.cmd_addr = init_cmd_addr(state_q);
          fields.cmd_data = init_cmd_data(state_q);
          if (init_cnt_q == CNT_LAST) begin
            init_cnt_d = '0;
            case (state_q)
              ST_RST:  state_d = ST_MVOL;
              ST_MVOL: state_d = ST_PVOL;
              default: begin
                // An empty song skips PLAY entirely but still reports completion.
                if (len_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end else begin
                  state_d = ST_PLAY;
                end
              end
            endcase
          end else begin
            init_cnt_d = init_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (ac97_strobe) begin
          frame_load = 1'b1;
          if (at_end) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            fields.valid[3:2] = 2'b11;
            fields.pcm        = smp_data;
            smp_addr_d        = smp_addr_q + ADDR_W'(1);
            if (cmd_valid) begin
              fields.valid[1:0] = 2'b11;
              fields.cmd_addr   = cmd_addr;
              fields.cmd_data   = cmd_data;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_d = frame_load ? frame_packed : frame_q;

  always_ff @(posedge ac97_bitclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      init_cnt_q <= '0;
      smp_addr_q <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      smp_addr_q <= smp_addr_d;
      len_q      <= len_d;
      done_q     <= done_d;
      frame_q    <= frame_d;
    end
  end

  assign cmd_ready = (state_q == ST_PLAY) & ac97_strobe & ~at_end;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign smp_addr  = smp_addr_q;
  assign frame     = frame_q;

endmodule
